// File: rtl/inv_butterfly_pipe.sv
// Inverse 4-point partial butterfly: recombines even/odd terms into four samples,
// then rounds, shifts and clips them in a two-stage valid/ready pipeline.
module inv_butterfly_pipe #(
    parameter int WIDTH     = 17,
    parameter int SHIFT     = 7,
    parameter int OUT_WIDTH = 16,
    parameter int ROWS      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_e0,
    input  logic signed [WIDTH-1:0]     in_e1,
    input  logic signed [WIDTH-1:0]     in_o0,
    input  logic signed [WIDTH-1:0]     in_o1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out0,
    output logic signed [OUT_WIDTH-1:0] out1,
    output logic signed [OUT_WIDTH-1:0] out2,
    output logic signed [OUT_WIDTH-1:0] out3,
    output logic                        out_last,
    output logic                        out_sat
);
    localparam int S1W = WIDTH + 1;
    localparam int S2W = WIDTH + 2;
    localparam int XW  = ((S2W > OUT_WIDTH) ? S2W : OUT_WIDTH) + 1;
    localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [S2W-1:0] RND      = (SHIFT > 0) ? (S2W'(1) << RSH) : '0;
    localparam logic signed [XW-1:0]  SAT_MAX  = {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0]  SAT_MIN  = ~SAT_MAX;
    localparam logic [CW-1:0]         ROW_LAST = CW'(ROWS - 1);

    logic                        adv1;
    logic                        adv2;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [S1W-1:0]       s1_q [4];
    logic signed [S1W-1:0]       s1_d [4];
    logic                        s2_valid_q, s2_valid_d;
    logic signed [OUT_WIDTH-1:0] s2_q [4];
    logic signed [OUT_WIDTH-1:0] s2_d [4];
    logic                        sat_q, sat_d;
    logic [CW-1:0]               row_q, row_d;

    logic signed [S1W-1:0]       e0_x, e1_x, o0_x, o1_x;
    logic signed [S2W-1:0]       rnd_sum [4];
    logic signed [S2W-1:0]       shifted [4];
    logic signed [XW-1:0]        wide    [4];
    logic signed [OUT_WIDTH-1:0] clipped [4];
    logic [3:0]                  clip_hit;

    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
    end

    // Stage 1: one extra bit holds any sum or difference of two WIDTH-bit terms.
    always_comb begin
        e0_x       = {in_e0[WIDTH-1], in_e0};
        e1_x       = {in_e1[WIDTH-1], in_e1};
        o0_x       = {in_o0[WIDTH-1], in_o0};
        o1_x       = {in_o1[WIDTH-1], in_o1};
        s1_valid_d = s1_valid_q;
        for (int i = 0; i < 4; i++) begin
            s1_d[i] = s1_q[i];
        end
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d[0] = e0_x + o0_x;
                s1_d[1] = e1_x + o1_x;
                s1_d[2] = e1_x - o1_x;
                s1_d[3] = e0_x - o0_x;
            end
        end
    end

    // Round-half-up then floor shift; the extra headroom bit absorbs the rounding add.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rnd_sum[i]  = S2W'(s1_q[i]) + RND;
            shifted[i]  = rnd_sum[i] >>> SHIFT;
            wide[i]     = XW'(shifted[i]);
            clip_hit[i] = (wide[i] > SAT_MAX) || (wide[i] < SAT_MIN);
            if (wide[i] > SAT_MAX) begin
                clipped[i] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (wide[i] < SAT_MIN) begin
                clipped[i] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                clipped[i] = wide[i][OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        sat_d      = sat_q;
        for (int i = 0; i < 4; i++) begin
            s2_d[i] = s2_q[i];
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sat_d = |clip_hit;
                for (int i = 0; i < 4; i++) begin
                    s2_d[i] = clipped[i];
                end
            end
        end
        row_d = row_q;
        if (s2_valid_q && out_ready) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sat_q      <= 1'b0;
            row_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sat_q      <= sat_d;
            row_q      <= row_d;
            for (int i = 0; i < 4; i++) begin
                s1_q[i] <= s1_d[i];
                s2_q[i] <= s2_d[i];
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out0      = s2_q[0];
    assign out1      = s2_q[1];
    assign out2      = s2_q[2];
    assign out3      = s2_q[3];
    assign out_sat   = sat_q;
    assign out_last  = s2_valid_q && (row_q == ROW_LAST);

endmodule
